// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache in front of fetch; misses go to the memory controller.
// Optional ICACHE_STATS_EN adds hit/miss counters on hit_cnt/miss_cnt.
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] pc_in,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_e;

  state_e                    state_q, state_d;
  logic                      inst_valid_q, inst_valid_d;
  logic [31:0]               inst_out_q, inst_out_d;
  logic                      mc_req_q, mc_req_d;
  logic [31:0]               mc_addr_q, mc_addr_d;
  logic                      stale_q, stale_d;
  logic [LINES-1:0]          valid_q;
  logic [TAG_BITS-1:0]       tag_q  [LINES];
  logic [31:0]               data_q [LINES];

  logic [INDEX_BITS-1:0]     lk_idx, fill_idx;
  logic [TAG_BITS-1:0]       lk_tag, fill_tag;
  logic                      hit, fill_we, hit_inc, miss_inc;
  logic                      unused_pc_bits;

  assign lk_idx   = pc_in[INDEX_BITS+1:2];
  assign lk_tag   = pc_in[31:INDEX_BITS+2];
  assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mc_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  // Byte offset is irrelevant for word-aligned fetch.
  assign unused_pc_bits = ^pc_in[1:0];

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    inst_valid_d = 1'b0;
    inst_out_d   = inst_out_q;
    mc_req_d     = mc_req_q;
    mc_addr_d    = mc_addr_q;
    stale_d      = stale_q;
    fill_we      = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!clear) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_out_d   = data_q[lk_idx];
            hit_inc      = 1'b1;
          end else begin
            mc_req_d  = 1'b1;
            mc_addr_d = {pc_in[31:2], 2'b00};
            stale_d   = 1'b0;
            miss_inc  = 1'b1;
            state_d   = MISS;
          end
        end
      end
      MISS: begin
        if (mc_done) begin
          // The line is filled even when fetch has since been flushed.
          fill_we  = 1'b1;
          mc_req_d = 1'b0;
          state_d  = IDLE;
          if (!stale_q && !clear) begin
            inst_valid_d = 1'b1;
            inst_out_d   = mc_data;
          end
        end else if (clear) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      mc_req_q     <= 1'b0;
      mc_addr_q    <= '0;
      stale_q      <= 1'b0;
      valid_q      <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      mc_req_q     <= mc_req_d;
      mc_addr_q    <= mc_addr_d;
      stale_q      <= stale_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc_data;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign mc_req     = mc_req_q;
  assign mc_addr    = mc_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hits, conflicts, flushes, rdy stalls, reset.
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, mc_done;
  logic [31:0] pc_in, mc_data;
  logic        inst_valid, mc_req;
  logic [31:0] inst_out, mc_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  icache #(.INDEX_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .pc_in      (pc_in),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .mc_req     (mc_req),
    .mc_addr    (mc_addr),
    .mc_done    (mc_done),
    .mc_data    (mc_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; mc_done = 1'b0;
    pc_in = 32'h0; mc_data = 32'h0;
    tick(); tick();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_out",   inst_out, 32'h0);
    check("rst_req",   {31'd0, mc_req}, 32'd0);
    check("rst_addr",  mc_addr, 32'h0);
    rst = 1'b0;

    // Cold miss at 0x0
    pc_in = 32'h0; tick();
    check("cold_req",   {31'd0, mc_req}, 32'd1);
    check("cold_addr",  mc_addr, 32'h0);
    check("cold_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("cold_wait_req", {31'd0, mc_req}, 32'd1);
    mc_done = 1'b1; mc_data = 32'h0000_0013; tick(); mc_done = 1'b0;
    check("fill_valid", {31'd0, inst_valid}, 32'd1);
    check("fill_out",   inst_out, 32'h0000_0013);
    check("fill_req",   {31'd0, mc_req}, 32'd0);

    // Repeated PC re-hits
    tick();
    check("hit0_valid", {31'd0, inst_valid}, 32'd1);
    check("hit0_out",   inst_out, 32'h0000_0013);
    check("hit0_req",   {31'd0, mc_req}, 32'd0);

    // Fill 0x4, then back-to-back hits 0x0, 0x4
    pc_in = 32'h4; tick();
    check("m4_addr", mc_addr, 32'h4);
    mc_done = 1'b1; mc_data = 32'h0010_0093; tick(); mc_done = 1'b0;
    check("f4_out", inst_out, 32'h0010_0093);
    pc_in = 32'h0; tick();
    check("b2b0_valid", {31'd0, inst_valid}, 32'd1);
    check("b2b0_out",   inst_out, 32'h0000_0013);
    pc_in = 32'h4; tick();
    check("b2b4_valid", {31'd0, inst_valid}, 32'd1);
    check("b2b4_out",   inst_out, 32'h0010_0093);

    // Conflict: 0x400 maps to index 0
    pc_in = 32'h400; tick();
    check("conf_req",  {31'd0, mc_req}, 32'd1);
    check("conf_addr", mc_addr, 32'h400);
    mc_done = 1'b1; mc_data = 32'hAAAA_0001; tick(); mc_done = 1'b0;
    check("conf_valid", {31'd0, inst_valid}, 32'd1);
    check("conf_out",   inst_out, 32'hAAAA_0001);
    pc_in = 32'h0; tick();
    check("evict_req",  {31'd0, mc_req}, 32'd1);
    check("evict_addr", mc_addr, 32'h0);
    mc_done = 1'b1; mc_data = 32'h0000_0013; tick(); mc_done = 1'b0;
    check("refill_out", inst_out, 32'h0000_0013);

    // Flush mid-miss at 0x10; pc_in changes are ignored while waiting
    pc_in = 32'h10; tick();
    check("fl_addr", mc_addr, 32'h10);
    pc_in = 32'h20; tick();
    check("fl_addr_hold", mc_addr, 32'h10);
    clear = 1'b1; tick(); clear = 1'b0;
    check("fl_req_kept", {31'd0, mc_req}, 32'd1);
    mc_done = 1'b1; mc_data = 32'hDEAD_BEEF; tick(); mc_done = 1'b0;
    check("fl_valid", {31'd0, inst_valid}, 32'd0);
    check("fl_req",   {31'd0, mc_req}, 32'd0);
    pc_in = 32'h10; tick();
    check("fl_hit_valid", {31'd0, inst_valid}, 32'd1);
    check("fl_hit_out",   inst_out, 32'hDEAD_BEEF);

    // Simultaneous clear + mc_done
    pc_in = 32'h14; tick();
    check("sim_req", {31'd0, mc_req}, 32'd1);
    clear = 1'b1; mc_done = 1'b1; mc_data = 32'h0000_0055; tick();
    clear = 1'b0; mc_done = 1'b0;
    check("sim_valid", {31'd0, inst_valid}, 32'd0);
    check("sim_req_drop", {31'd0, mc_req}, 32'd0);
    tick();
    check("sim_hit_out", inst_out, 32'h0000_0055);

    // Clear during an IDLE hit
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_hit_valid", {31'd0, inst_valid}, 32'd0);
    check("clr_hit_req",   {31'd0, mc_req}, 32'd0);

    // rdy=0 for 3 cycles mid-miss: request held, mc_done ignored
    pc_in = 32'h18; tick();
    check("rdy_addr", mc_addr, 32'h18);
    rdy = 1'b0; mc_done = 1'b1; mc_data = 32'h0000_0077; pc_in = 32'h24;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy0_req",   {31'd0, mc_req}, 32'd1);
      check("rdy0_addr",  mc_addr, 32'h18);
      check("rdy0_valid", {31'd0, inst_valid}, 32'd0);
    end
    rdy = 1'b1; mc_done = 1'b0; tick();
    check("rdy1_req", {31'd0, mc_req}, 32'd1);
    mc_done = 1'b1; mc_data = 32'h0000_0099; tick(); mc_done = 1'b0;
    check("rdy_fill_valid", {31'd0, inst_valid}, 32'd1);
    check("rdy_fill_out",   inst_out, 32'h0000_0099);
    rdy = 1'b0; tick();
    check("rdy0_hold_valid", {31'd0, inst_valid}, 32'd1);
    rdy = 1'b1;

    // mc_done while IDLE is ignored
    pc_in = 32'h18; mc_done = 1'b1; mc_data = 32'h0000_1234; tick(); mc_done = 1'b0;
    check("idle_done_out", inst_out, 32'h0000_0099);
    check("idle_done_req", {31'd0, mc_req}, 32'd0);

    // Reset clears valid bits; then cold miss, 3 hits, 1 conflict miss
    rst = 1'b1; pc_in = 32'h0; tick(); rst = 1'b0;
`ifdef ICACHE_STATS_EN
    check("st_rst_hit",  hit_cnt, 32'd0);
    check("st_rst_miss", miss_cnt, 32'd0);
`endif
    tick();
    check("rst_inv_req", {31'd0, mc_req}, 32'd1);
    mc_done = 1'b1; mc_data = 32'h0000_0013; tick(); mc_done = 1'b0;
    tick(); tick(); tick();
    check("st_hit3_out", inst_out, 32'h0000_0013);
    pc_in = 32'h400; tick();
    check("st_conf_req", {31'd0, mc_req}, 32'd1);
`ifdef ICACHE_STATS_EN
    check("st_hit",  hit_cnt, 32'd3);
    check("st_miss", miss_cnt, 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("st_rst2_hit",  hit_cnt, 32'd0);
    check("st_rst2_miss", miss_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
